// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state codes, the blank display code and the digit-count helper.
package bin2bcd_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] BCD_BLANK = 4'd10;

  // Decimal digits of 2^bin_w - 1 = floor(bin_w * log10(2)) + 1.
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// One double-dabble correction stage: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3_digit (
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);

  assign o_dig = (i_dig >= 4'd5) ? i_dig + 4'd3 : i_dig;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock,
// valid/ready on both sides. Define BIN2BCD_LZB_EN for leading-zero blanking on o_dec.
//
// state | meaning
// IDLE  | o_ready=1, waiting for an operand
// SHIFT | add-3 then shift, BIN_W cycles
// DONE  | result held on o_bcd, o_valid asserted, waiting for i_ready
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int DIG_N = 5,
  parameter int SEL_W = (DIG_N > 1) ? $clog2(DIG_N) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [BIN_W-1:0]   i_bin,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [4*DIG_N-1:0] o_bcd,
  input  logic [SEL_W-1:0]   i_sel,
  output logic [3:0]         o_dec
);

  localparam int BCD_W = 4 * DIG_N;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  generate
    if (BIN_W < 1) begin : g_bin_w_chk
      $error("bin2bcd_seq: BIN_W must be at least 1");
    end
    if (DIG_N < min_digits(BIN_W)) begin : g_dig_n_chk
      $error("bin2bcd_seq: DIG_N too small for BIN_W");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] work_q, work_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  int               sel_int;

  for (genvar g = 0; g < DIG_N; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_dig (work_q[4*g +: 4]),
      .o_dig (adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          bin_d   = i_bin;
          work_d  = '0;
          cnt_d   = CNT_W'(BIN_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {work_d, bin_d} = {adj, bin_q} << 1;
        if (cnt_q == '0) begin
          bcd_d   = work_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (valid_q && i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // o_valid follows the DONE state by one register stage
    valid_d = (state_q == DONE) && !(valid_q && i_ready);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    sel_int = int'(i_sel);
    o_dec   = BCD_BLANK;
    for (int k = 0; k < DIG_N; k++) begin
      if (k == sel_int) o_dec = bcd_q[4*k +: 4];
    end
`ifdef BIN2BCD_LZB_EN
    begin : b_lzb
      logic upper_nz;
      upper_nz = 1'b0;
      for (int k = 0; k < DIG_N; k++) begin
        if (k >= sel_int && bcd_q[4*k +: 4] != 4'd0) upper_nz = 1'b1;
      end
      if (sel_int > 0 && !upper_nz) o_dec = BCD_BLANK;
    end
`endif
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_bcd   = bcd_q;

endmodule
